// File: rtl/axi_chan_fifo_pkg.sv
// Shared definitions for the AXI channel FIFO: sizing helpers and the
// channel payload structs carried as DATA_WIDTH-bit words.
package axi_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Registered-output mode holds one extra entry in the output register.
  function automatic int fifo_cap(input int depth, input int fwft);
    return (fwft != 0) ? depth : depth + 1;
  endfunction

  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [27:0] addr;
  } ar_req_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [27:0] addr;
  } aw_req_t;

  typedef struct packed {
    logic [3:0]  strb;
    logic        last;
    logic [26:0] data;
  } w_beat_t;

endpackage

// File: rtl/axi_chan_fifo_if.sv
// One valid/ready channel. A transfer happens on a rising edge where valid
// and ready are both high; once valid rises, data holds until that transfer.
interface axi_chan_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axi_chan_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one async read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_chan_fifo.sv
// Channel FIFO with FWFT or registered-output head, occupancy flags,
// high-water mark and synchronous flush.
module axi_chan_fifo
  import axi_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 2,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  axi_chan_fifo_if.slave        s,
  axi_chan_fifo_if.master       m,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   max_level
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CAP   = fifo_cap(DEPTH, FWFT);
  localparam int LW    = level_width(ADDR_WIDTH);
  localparam logic [LW-1:0] CAP_L = LW'(CAP);
  localparam logic [LW-1:0] AF_L  = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_L  = LW'(AEMPTY_THRESH);

  logic                  push, pop;
  logic [LW-1:0]         level_nxt;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic                  ram_we, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign s.ready      = (level != CAP_L);
  assign m.valid      = (level != '0);
  assign push         = s.valid && s.ready;
  assign pop          = m.valid && m.ready;
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      level     <= '0;
      max_level <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      level <= level_nxt;
      if (level_nxt > max_level) max_level <= level_nxt;
      if (ram_we) wptr <= wptr + 1'b1;
      if (ram_re) rptr <= rptr + 1'b1;
    end
  end

  fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wptr),
    .wdata (s.data),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign ram_we = push;
    assign ram_re = pop;
    assign m.data = ram_rdata;
  end else begin : g_oreg
    logic                  ovld;
    logic [DATA_WIDTH-1:0] oreg;
    logic                  ram_empty;
    logic                  to_oreg;

    // RAM occupancy excludes the entry sitting in the output register.
    assign ram_empty = ((level - LW'(ovld)) == '0);
    // A push that coincides with the pop of the last entry goes straight
    // to the output register so the head never goes stale.
    assign to_oreg   = push && (!ovld || (pop && ram_empty));
    assign ram_we    = push && !to_oreg;
    assign ram_re    = pop && !ram_empty;
    assign m.data    = oreg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ovld <= 1'b0;
        oreg <= '0;
      end else if (flush) begin
        ovld <= 1'b0;
      end else if (ram_re) begin
        oreg <= ram_rdata;
      end else if (to_oreg) begin
        oreg <= s.data;
        ovld <= 1'b1;
      end else if (pop) begin
        ovld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_chan_fifo.sv
// Bench for axi_chan_fifo: an FWFT and a registered-output instance share
// one stimulus stream, each scored against its own queue model.
module tb_axi_chan_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b0;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_chan_fifo_if #(.DATA_WIDTH(32)) s1 ();
  axi_chan_fifo_if #(.DATA_WIDTH(32)) m1 ();
  axi_chan_fifo_if #(.DATA_WIDTH(32)) s0 ();
  axi_chan_fifo_if #(.DATA_WIDTH(32)) m0 ();

  logic [2:0] lvl1, lvl0, mx1, mx0;
  logic       af1, af0, ae1, ae0;

  assign s1.valid = s_valid;
  assign s1.data  = s_data;
  assign m1.ready = m_ready;
  assign s0.valid = s_valid;
  assign s0.data  = s_data;
  assign m0.ready = m_ready;

  axi_chan_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(1),
                  .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(s1), .m(m1),
    .level(lvl1), .almost_full(af1), .almost_empty(ae1), .max_level(mx1)
  );

  axi_chan_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .FWFT(0),
                  .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut_oreg (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s(s0), .m(m0),
    .level(lvl0), .almost_full(af0), .almost_empty(ae0), .max_level(mx0)
  );

  // Index 0 = FWFT instance (capacity 4), index 1 = registered-output (capacity 5).
  logic        rdy [2];
  logic        vld [2];
  logic [31:0] dat [2];
  logic [2:0]  lvl [2];
  logic [2:0]  mxl [2];
  logic        af  [2];
  logic        ae  [2];

  assign rdy[0] = s1.ready;  assign rdy[1] = s0.ready;
  assign vld[0] = m1.valid;  assign vld[1] = m0.valid;
  assign dat[0] = m1.data;   assign dat[1] = m0.data;
  assign lvl[0] = lvl1;      assign lvl[1] = lvl0;
  assign mxl[0] = mx1;       assign mxl[1] = mx0;
  assign af[0]  = af1;       assign af[1]  = af0;
  assign ae[0]  = ae1;       assign ae[1]  = ae0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard: exp_q holds accepted words in order; the monitor compares
  // the DUT outputs against the model on every falling edge.
  logic [31:0] exp_q [2][$];
  int          hi_mark [2];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int cap;
        int sz;
        bit do_pop;
        bit do_push;
        cap = (i == 0) ? 4 : 5;
        sz  = exp_q[i].size();
        chk($sformatf("dut%0d s_ready", i), 32'(rdy[i]), 32'(sz != cap));
        chk($sformatf("dut%0d m_valid", i), 32'(vld[i]), 32'(sz != 0));
        chk($sformatf("dut%0d level", i), 32'(lvl[i]), 32'(sz));
        chk($sformatf("dut%0d max_level", i), 32'(mxl[i]), 32'(hi_mark[i]));
        chk($sformatf("dut%0d almost_full", i), 32'(af[i]), 32'(sz >= 3));
        chk($sformatf("dut%0d almost_empty", i), 32'(ae[i]), 32'(sz <= 1));
        if (sz > 0) chk($sformatf("dut%0d m_data", i), dat[i], exp_q[i][0]);
        if (!rst_n || flush) begin
          exp_q[i].delete();
          hi_mark[i] = 0;
        end else begin
          do_pop  = m_ready && (sz != 0);
          do_push = s_valid && (sz != cap);
          if (do_pop) void'(exp_q[i].pop_front());
          if (do_push) exp_q[i].push_back(s_data);
          if (exp_q[i].size() > hi_mark[i]) hi_mark[i] = exp_q[i].size();
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    hi_mark[0] = 0;
    hi_mark[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("dut1 reset m_data", dat[1], 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Fill past capacity with the consumer stalled, then drain.
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'hA0 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    idle(1);

    // Steady push+pop at level 2.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) cyc(1'b1, 32'hB0 + 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b1, 32'hB2 + 32'(k), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Full FIFO with simultaneous push and pop.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'hC0 + 32'(k), 1'b0, 1'b0);
    cyc(1'b1, 32'hCF, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush together with push and pop at level 3.
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'hD0 + 32'(k), 1'b0, 1'b0);
    cyc(1'b1, 32'hDD, 1'b1, 1'b1);
    idle(1);
    for (int k = 0; k < 2; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream at level 2, then 0x55 must lead.
    for (int k = 0; k < 2; k++) cyc(1'b1, 32'hE0 + 32'(k), 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 32'hEE, 1'b1, 1'b0);
    chk("dut1 mid-reset m_data", dat[1], 32'h0);
    rst_n = 1'b1;
    cyc(1'b1, 32'h55, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int k = 0; k < 800; k++)
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 63) == 0));
    for (int k = 0; k < 8; k++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
